// File: rtl/vga_grid_pkg.sv
// Shared timing/grid constants, cell codes and arbiter state type for the
// snake-grid memory arbiter.
package vga_grid_pkg;

   localparam int DEF_HOR_FIELD = 800;
   localparam int DEF_HOR_TOTAL = 1042;
   localparam int DEF_VER_FIELD = 600;
   localparam int DEF_VER_TOTAL = 665;
   localparam int DEF_CELL_PX   = 20;
   localparam int DEF_GRID_COLS = 40;
   localparam int DEF_GRID_ROWS = 30;
   localparam int DEF_CELL_W    = 2;
   localparam int DEF_ADDR_W    = 11;
   localparam int COL_W         = 12;
   localparam int ROW_W         = 11;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SNAKE = 2'd1,
      FOOD  = 2'd2,
      WALL  = 2'd3
   } cell_code_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/cell_addr_gen.sv
// Converts the raster position into a grid cell index using sub-pixel and
// cell counters, so no divider or multiplier is needed.
module cell_addr_gen
   import vga_grid_pkg::*;
#(
   parameter int CELL_PX   = DEF_CELL_PX,
   parameter int GRID_COLS = DEF_GRID_COLS,
   parameter int ADDR_W    = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [COL_W-1:0]  i_col,
   input  logic [ROW_W-1:0]  i_row,
   output logic [ADDR_W-1:0] o_cellAddr
);

   localparam int SUB_W = $clog2(CELL_PX);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);

   logic [SUB_W-1:0]  r_colSub, w_colSub;
   logic [ADDR_W-1:0] r_colCell, w_colCell;
   logic [SUB_W-1:0]  r_rowSub, w_rowSub;
   logic [ADDR_W-1:0] r_rowBase, w_rowBase;

   // The row counters only move on the first pixel of a line; the registered
   // values always describe the previous cycle's position.
   always_comb begin
      w_colSub  = r_colSub + 1'b1;
      w_colCell = r_colCell;
      w_rowSub  = r_rowSub;
      w_rowBase = r_rowBase;
      if (i_col == '0) begin
         w_colSub  = '0;
         w_colCell = '0;
         if (i_row == '0) begin
            w_rowSub  = '0;
            w_rowBase = '0;
         end else if (r_rowSub == SUB_LAST) begin
            w_rowSub  = '0;
            w_rowBase = r_rowBase + ADDR_W'(GRID_COLS);
         end else begin
            w_rowSub  = r_rowSub + 1'b1;
         end
      end else if (r_colSub == SUB_LAST) begin
         w_colSub  = '0;
         w_colCell = r_colCell + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_colSub  <= '0;
         r_colCell <= '0;
         r_rowSub  <= '0;
         r_rowBase <= '0;
      end else begin
         r_colSub  <= w_colSub;
         r_colCell <= w_colCell;
         r_rowSub  <= w_rowSub;
         r_rowBase <= w_rowBase;
      end
   end

   assign o_cellAddr = w_rowBase + w_colCell;

endmodule

// File: rtl/grid_mem_arbiter.sv
// Shares a single-port grid RAM between the pixel renderer (absolute priority
// inside the visible window) and game logic (served during blanking).
module grid_mem_arbiter
   import vga_grid_pkg::*;
#(
   parameter int HOR_FIELD = DEF_HOR_FIELD,
   parameter int HOR_TOTAL = DEF_HOR_TOTAL,
   parameter int VER_FIELD = DEF_VER_FIELD,
   parameter int VER_TOTAL = DEF_VER_TOTAL,
   parameter int CELL_PX   = DEF_CELL_PX,
   parameter int GRID_COLS = DEF_GRID_COLS,
   parameter int GRID_ROWS = DEF_GRID_ROWS,
   parameter int CELL_W    = DEF_CELL_W,
   parameter int ADDR_W    = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [COL_W-1:0]  display_col,
   input  logic [ROW_W-1:0]  display_row,
   input  logic              g_req,
   input  logic              g_we,
   input  logic [ADDR_W-1:0] g_addr,
   input  logic [CELL_W-1:0] g_wdata,
   output logic              g_ack,
   output logic [CELL_W-1:0] g_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [CELL_W-1:0] mem_wdata,
   input  logic [CELL_W-1:0] mem_rdata,
   output logic [CELL_W-1:0] cell_code,
   output logic              frame_tick
);

   arb_state_e        r_state;
   logic              r_gAck, r_memWe, r_frameTick, r_zeroRdata;
   logic              r_winD1, r_winD2;
   logic [CELL_W-1:0] r_gRdata, r_memWdata, r_cellCode;
   logic [ADDR_W-1:0] r_memAddr;
   logic [ADDR_W-1:0] w_dispAddr;
   logic              w_inWindow, w_free, w_grant, w_oobReq;

   cell_addr_gen #(
      .CELL_PX   (CELL_PX),
      .GRID_COLS (GRID_COLS),
      .ADDR_W    (ADDR_W)
   ) u_cellAddrGen (
      .clock      (clock),
      .reset      (reset),
      .i_col      (display_col),
      .i_row      (display_row),
      .o_cellAddr (w_dispAddr)
   );

   assign w_inWindow = (display_col < COL_W'(HOR_FIELD)) && (display_row < ROW_W'(VER_FIELD));
   // Column slack stops two short of the line end so a game access can never
   // still be on the bus when the next line's first display address is issued.
   assign w_free     = ((display_row >= ROW_W'(VER_FIELD)) && (display_row < ROW_W'(VER_TOTAL))) ||
                       ((display_col >= COL_W'(HOR_FIELD)) && (display_col <= COL_W'(HOR_TOTAL - 3)));
   assign w_grant    = (r_state == IDLE) && g_req && w_free;
   assign w_oobReq   = (g_addr >= ADDR_W'(GRID_COLS * GRID_ROWS));

   // The mem_* registers double as the latched game request during ISSUE;
   // r_zeroRdata remembers whether the ack must return 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_gAck      <= 1'b0;
         r_gRdata    <= '0;
         r_memAddr   <= '0;
         r_memWe     <= 1'b0;
         r_memWdata  <= '0;
         r_cellCode  <= '0;
         r_frameTick <= 1'b0;
         r_zeroRdata <= 1'b0;
         r_winD1     <= 1'b0;
         r_winD2     <= 1'b0;
      end else begin
         r_frameTick <= (display_col == '0) && (display_row == ROW_W'(VER_FIELD));
         r_winD1     <= w_inWindow;
         r_winD2     <= r_winD1;
         r_cellCode  <= r_winD2 ? mem_rdata : '0;
         r_gAck      <= 1'b0;
         r_gRdata    <= '0;
         r_memWe     <= 1'b0;
         r_memWdata  <= '0;
         r_memAddr   <= w_inWindow ? w_dispAddr : '0;
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_memAddr   <= g_addr;
                  r_memWe     <= g_we && !w_oobReq;
                  r_memWdata  <= g_wdata;
                  r_zeroRdata <= g_we || w_oobReq;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: r_state <= WAIT;
            WAIT: begin
               r_gAck   <= 1'b1;
               r_gRdata <= r_zeroRdata ? '0 : mem_rdata;
               r_state  <= ACK;
            end
            ACK:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign g_ack      = r_gAck;
   assign g_rdata    = r_gRdata;
   assign mem_addr   = r_memAddr;
   assign mem_we     = r_memWe;
   assign mem_wdata  = r_memWdata;
   assign cell_code  = r_cellCode;
   assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter: drives a raster position, models the
// synchronous grid RAM and checks arbitration, pixel lookup and reset.
module tb_grid_mem_arbiter;
   import vga_grid_pkg::*;

   localparam int HOR_TOTAL_TB = 1042;
   localparam int VER_TOTAL_TB = 665;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] displayCol;
   logic [10:0] displayRow;
   logic        gReq, gWe;
   logic [10:0] gAddr;
   logic [1:0]  gWdata;
   logic        gAck;
   logic [1:0]  gRdata;
   logic [10:0] memAddr;
   logic        memWe;
   logic [1:0]  memWdata;
   logic [1:0]  memRdata;
   logic [1:0]  cellCode;
   logic        frameTick;

   logic [1:0]  ramArray [0:2047];

   int checkCount = 0;
   int errorCount = 0;
   int ackRow, ackCol, ackData;
   int pulses, tickRow, tickCol, resetAcks;

   always #5 clock = ~clock;

   grid_mem_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .display_col (displayCol),
      .display_row (displayRow),
      .g_req       (gReq),
      .g_we        (gWe),
      .g_addr      (gAddr),
      .g_wdata     (gWdata),
      .g_ack       (gAck),
      .g_rdata     (gRdata),
      .mem_addr    (memAddr),
      .mem_we      (memWe),
      .mem_wdata   (memWdata),
      .mem_rdata   (memRdata),
      .cell_code   (cellCode),
      .frame_tick  (frameTick)
   );

   // Read-first synchronous RAM, preloaded with a few marker cells on reset
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2048; i++) ramArray[i] <= 2'd0;
         ramArray[0]  <= SNAKE;
         ramArray[41] <= FOOD;
         ramArray[79] <= SNAKE;
         ramArray[80] <= WALL;
         memRdata     <= 2'd0;
      end else begin
         if (memWe) ramArray[memAddr] <= memWdata;
         memRdata <= ramArray[memAddr];
      end
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
      if (int'(displayCol) == HOR_TOTAL_TB) begin
         displayCol = 12'd0;
         displayRow = (int'(displayRow) == VER_TOTAL_TB) ? 11'd0 : displayRow + 11'd1;
      end else begin
         displayCol = displayCol + 12'd1;
      end
   endtask

   task automatic jumpTo(input int r, input int c);
      @(posedge clock);
      #1;
      displayRow = r[10:0];
      displayCol = c[11:0];
   endtask

   task automatic runTo(input int r, input int c);
      for (int i = 0; i < 40000 && !(int'(displayRow) == r && int'(displayCol) == c); i++)
         stepCycle();
      checkOutput("runTo", int'(displayRow) * 2048 + int'(displayCol), r * 2048 + c);
   endtask

   task automatic applyStimulus(input int we, input int addr, input int wdata);
      gReq   = 1'b1;
      gWe    = we[0];
      gAddr  = addr[10:0];
      gWdata = wdata[1:0];
   endtask

   task automatic waitAck(input int keepReq, output int aRow, output int aCol, output int aData);
      int found = 0;
      aRow = -1; aCol = -1; aData = -1;
      for (int i = 0; i < 3000 && found == 0; i++) begin
         stepCycle();
         if (gAck) begin
            found = 1;
            aRow  = int'(displayRow);
            aCol  = int'(displayCol);
            aData = int'(gRdata);
         end
      end
      checkOutput("ackSeen", found, 1);
      if (keepReq == 0) gReq = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      gReq = 0; gWe = 0; gAddr = '0; gWdata = '0;
      displayCol = '0; displayRow = '0; reset = 1'b0;
      #12;
      checkOutput("rstAck", int'(gAck), 0);
      checkOutput("rstMemAddr", int'(memAddr), 0);
      checkOutput("rstMemWe", int'(memWe), 0);
      checkOutput("rstCellCode", int'(cellCode), 0);
      checkOutput("rstFrameTick", int'(frameTick), 0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Cell 0 seen three cycles after pixel (0,0)
      runTo(0, 3);
      checkOutput("cellRow0", int'(cellCode), 1);

      // Read during visible area waits for horizontal blanking
      runTo(10, 100);
      applyStimulus(0, 41, 0);
      waitAck(0, ackRow, ackCol, ackData);
      checkOutput("heldAckRow", ackRow, 10);
      checkOutput("heldAckCol", ackCol, 803);
      checkOutput("heldRdata", ackData, 2);
      stepCycle();
      checkOutput("ackPulse", int'(gAck), 0);

      // Write in blanking
      runTo(10, 900);
      applyStimulus(1, 5, 2);
      stepCycle();
      checkOutput("wrMemWe", int'(memWe), 1);
      checkOutput("wrMemAddr", int'(memAddr), 5);
      checkOutput("wrMemWdata", int'(memWdata), 2);
      waitAck(0, ackRow, ackCol, ackData);
      checkOutput("wrAckCol", ackCol, 903);
      checkOutput("wrRdata", ackData, 0);

      runTo(10, 950);
      applyStimulus(0, 5, 0);
      waitAck(0, ackRow, ackCol, ackData);
      checkOutput("rdAckCol", ackCol, 953);
      checkOutput("rdRdata", ackData, 2);

      // Out-of-range write is acked but never reaches the RAM
      runTo(10, 1000);
      applyStimulus(1, 1500, 3);
      stepCycle();
      checkOutput("oobMemWe", int'(memWe), 0);
      waitAck(0, ackRow, ackCol, ackData);
      checkOutput("oobAckCol", ackCol, 1003);
      checkOutput("oobRdata", ackData, 0);

      // Last free column still issues and completes before the next line
      runTo(10, 1039);
      applyStimulus(0, 5, 0);
      stepCycle();
      checkOutput("lateMemAddr", int'(memAddr), 5);
      waitAck(0, ackRow, ackCol, ackData);
      checkOutput("lateAckRow", ackRow, 10);
      checkOutput("lateAckCol", ackCol, 1042);
      stepCycle();
      checkOutput("noGameAtCol0", int'(memAddr == 11'd5), 0);

      // Too late in the line: held through the next visible line
      runTo(11, 1040);
      applyStimulus(0, 41, 0);
      waitAck(0, ackRow, ackCol, ackData);
      checkOutput("wrapAckRow", ackRow, 12);
      checkOutput("wrapAckCol", ackCol, 803);
      checkOutput("wrapRdata", ackData, 2);

      // Request held high right after ack is a fresh request
      runTo(13, 900);
      applyStimulus(0, 5, 0);
      waitAck(1, ackRow, ackCol, ackData);
      checkOutput("b2bFirstCol", ackCol, 903);
      applyStimulus(1, 6, 1);
      stepCycle();
      stepCycle();
      checkOutput("b2bMemWe", int'(memWe), 1);
      checkOutput("b2bMemAddr", int'(memAddr), 6);
      waitAck(0, ackRow, ackCol, ackData);
      checkOutput("b2bSecondCol", ackCol, 907);

      // Pixel lookup alignment and horizontal window edge
      runTo(20, 22);
      checkOutput("cellCol19", int'(cellCode), 0);
      runTo(20, 23);
      checkOutput("cellCol20", int'(cellCode), 2);
      runTo(20, 42);
      checkOutput("cellCol39", int'(cellCode), 2);
      runTo(20, 43);
      checkOutput("cellCol40", int'(cellCode), 0);
      runTo(20, 802);
      checkOutput("cellCol799", int'(cellCode), 1);
      runTo(20, 803);
      checkOutput("cellCol800", int'(cellCode), 0);

      // Frame tick across the start of vertical blanking
      jumpTo(599, 1000);
      pulses = 0; tickRow = -1; tickCol = -1;
      for (int i = 0; i < 1200; i++) begin
         stepCycle();
         if (frameTick) begin
            pulses++;
            tickRow = int'(displayRow);
            tickCol = int'(displayCol);
         end
      end
      checkOutput("tickCount", pulses, 1);
      checkOutput("tickRow", tickRow, 600);
      checkOutput("tickCol", tickCol, 1);

      // Vertical blanking frees the RAM at any column
      runTo(602, 100);
      applyStimulus(0, 41, 0);
      waitAck(0, ackRow, ackCol, ackData);
      checkOutput("vblankAckCol", ackCol, 103);
      checkOutput("vblankRdata", ackData, 2);
      checkOutput("vblankCell", int'(cellCode), 0);

      // Reset while the FSM is in WAIT drops the request
      runTo(602, 200);
      applyStimulus(0, 41, 0);
      stepCycle();
      checkOutput("preRstMemAddr", int'(memAddr), 41);
      stepCycle();
      reset = 1'b0;
      #1;
      checkOutput("midRstAck", int'(gAck), 0);
      checkOutput("midRstRdata", int'(gRdata), 0);
      checkOutput("midRstMemAddr", int'(memAddr), 0);
      gReq = 1'b0;
      resetAcks = 0;
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         if (gAck) resetAcks++;
      end
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         if (gAck) resetAcks++;
      end
      checkOutput("droppedAck", resetAcks, 0);
      runTo(602, 300);
      applyStimulus(0, 41, 0);
      waitAck(0, ackRow, ackCol, ackData);
      checkOutput("postRstAckCol", ackCol, 303);
      checkOutput("postRstRdata", ackData, 2);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/grid_mem_arbiter.md
GRID_MEM_ARBITER -- requirements
Module: grid_mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): HOR_FIELD, 800, visible columns; HOR_TOTAL, 1042, last column index.
REQ-002 Parameters SHALL continue: VER_FIELD, 600, visible rows; VER_TOTAL, 665, last row index.
REQ-003 Parameters SHALL continue: CELL_PX, 20, cell edge in pixels; GRID_COLS, 40; GRID_ROWS, 30; CELL_W, 2, cell code width; ADDR_W, 11.
REQ-004 Ports SHALL be: clock  in  1  sole clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 display_col  in  12  horizontal counter from timing generator.
REQ-007 display_row  in  11  vertical counter from timing generator.
REQ-008 g_req  in  1  game-logic request, held until g_ack.
REQ-009 g_we  in  1  1 = write, 0 = read.
REQ-010 g_addr  in  ADDR_W  cell index.
REQ-011 g_wdata  in  CELL_W  write data.
REQ-012 g_ack  out  1  one-cycle completion pulse.
REQ-013 g_rdata  out  CELL_W  read data, valid with g_ack.
REQ-014 mem_addr  out  ADDR_W; mem_we  out  1; mem_wdata  out  CELL_W  single-port grid RAM controls, all registered.
REQ-015 mem_rdata  in  CELL_W  RAM data, valid one cycle after mem_addr.
REQ-016 cell_code  out  CELL_W  cell under current pixel, to renderer.
REQ-017 frame_tick  out  1  one-cycle pulse at start of vertical blanking.

Function
REQ-018 Display window SHALL be display_col < HOR_FIELD and display_row < VER_FIELD; the display owns the RAM inside it, with absolute priority.
REQ-019 Display address SHALL be (display_row/CELL_PX)*GRID_COLS + display_col/CELL_PX, generated with sub-pixel and cell counters cleared at display_col==0 / display_row==0; no divider or multiplier.
REQ-020 cell_code SHALL lag its display_col/display_row input by exactly 3 cycles: address register, RAM, output register.
REQ-021 cell_code SHALL be 0 for pixels outside the display window, with the same 3-cycle alignment.
REQ-022 The RAM SHALL be "free" when (VER_FIELD <= display_row < VER_TOTAL) or (HOR_FIELD <= display_col <= HOR_TOTAL-3).
REQ-023 The game FSM SHALL have states IDLE, ISSUE, WAIT, ACK.
REQ-024 IDLE->ISSUE SHALL occur when g_req && free, latching g_we, g_addr and g_wdata.
REQ-025 ISSUE SHALL drive the latched request onto mem_*, with mem_we = latched g_we.
REQ-026 WAIT SHALL be one cycle, after which the FSM enters ACK.
REQ-027 ACK SHALL pulse g_ack=1 with g_rdata = mem_rdata (0 for writes), then return to IDLE.
REQ-028 An issued request SHALL always complete; ISSUE never overlaps the display window.
REQ-029 g_req high in the cycle after ACK SHALL be treated as a new request.
REQ-030 For g_addr >= GRID_COLS*GRID_ROWS, mem_we SHALL be suppressed, g_rdata SHALL be 0, and the request SHALL still be acked.
REQ-031 frame_tick SHALL be 1 for exactly the one cycle after display_col==0 && display_row==VER_FIELD.

Reset
REQ-032 While reset==0, all outputs SHALL be 0, the FSM SHALL be IDLE and all counters 0, asynchronously.
REQ-033 A request in flight during reset SHALL be dropped with no g_ack.

Structure
REQ-034 A package vga_grid_pkg SHALL hold the timing/grid constants, the cell code enum (EMPTY=0, SNAKE=1, FOOD=2, WALL=3) and the FSM state type.
REQ-035 The sub-module cell_addr_gen SHALL own the counter-based col/row to cell-address conversion.

Verification
REQ-036 g_req write addr 5, data 2, at col 900 row 10 -> mem_we=1 at col 901, g_ack at col 903; a later read of addr 5 returns g_rdata=2.
REQ-037 g_req at col 100 row 10 -> no ISSUE until col 800, g_ack at col 803.
REQ-038 g_req at col 1040 row 10 -> held; issued at col 800 of row 11. A request seen at col 1039 issues at col 1040 with mem_addr never driven by the game at col 0.
REQ-039 RAM preloaded cell 41 = FOOD, col 20 row 20 applied -> cell_code=2 three cycles later; col 800 -> cell_code=0.
REQ-040 Write to g_addr 1500 -> mem_we stays 0, g_ack with g_rdata=0. Also: frame_tick pulses once per frame, cycle after row 600 col 0.
REQ-041 reset low during WAIT -> all outputs 0 immediately, no g_ack; after release, a new request completes normally.
